// File: rtl/inta_sequencer.sv
// CPU-side interrupt sequencer: raises INT, runs the two-pulse 8086 INTA cycle,
// maintains the In-Service Register and drives the vector byte.
module inta_sequencer #(
    parameter int unsigned SPURIOUS_LEVEL = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] chosen_interrupt,
    input  logic       inta_n,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       eoi,
    input  logic       specific_eoi,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] isr,
    output logic [7:0] clear_irr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [2:0] {IDLE, PENDING, ACK1, GAP, ACK2} state_t;

    state_t     state, state_nxt;
    logic       inta_prev;
    logic [2:0] level, level_nxt;
    logic       spurious, spurious_nxt;
    logic       int_nxt, oe_nxt;
    logic [7:0] isr_nxt, clear_nxt, dout_nxt;
    logic       fall, rise;
    logic [2:0] req_idx, isr_low;
    logic       req_any, eligible;

    assign fall = inta_prev & ~inta_n;
    assign rise = ~inta_prev & inta_n;

    // Scanning from bit 7 down lets the lowest set bit be the last write.
    always_comb begin
        req_idx = '0;
        isr_low = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (chosen_interrupt[7-i]) req_idx = 3'(7 - i);
            if (isr[7-i])              isr_low = 3'(7 - i);
        end
        req_any  = |chosen_interrupt;
        eligible = req_any && ((isr == '0) || (req_idx < isr_low));
    end

    always_comb begin
        state_nxt    = state;
        level_nxt    = level;
        spurious_nxt = spurious;
        int_nxt      = int_out;
        clear_nxt    = '0;
        dout_nxt     = data_out;
        oe_nxt       = data_oe;
        isr_nxt      = isr;

        // EOI clears are applied before any set so a same-bit set wins.
        if (eoi) begin
            if (specific_eoi) isr_nxt[eoi_level] = 1'b0;
            else              isr_nxt = isr & (isr - 8'd1);
        end

        case (state)
            IDLE: begin
                if (eligible) begin
                    state_nxt = PENDING;
                    int_nxt   = 1'b1;
                end
            end
            PENDING: begin
                if (fall) begin
                    int_nxt   = 1'b0;
                    state_nxt = ACK1;
                    if (req_any) begin
                        level_nxt          = req_idx;
                        spurious_nxt       = 1'b0;
                        isr_nxt[req_idx]   = 1'b1;
                        clear_nxt[req_idx] = 1'b1;
                    end else begin
                        level_nxt    = 3'(SPURIOUS_LEVEL);
                        spurious_nxt = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (rise) state_nxt = GAP;
            end
            GAP: begin
                if (fall) begin
                    dout_nxt  = {vector_base, level};
                    oe_nxt    = 1'b1;
                    state_nxt = ACK2;
                end
            end
            ACK2: begin
                if (rise) begin
                    oe_nxt = 1'b0;
                    if (auto_eoi && !spurious) isr_nxt[level] = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            inta_prev <= 1'b1;
            level     <= '0;
            spurious  <= 1'b0;
            int_out   <= 1'b0;
            isr       <= '0;
            clear_irr <= '0;
            data_out  <= '0;
            data_oe   <= 1'b0;
        end else begin
            state     <= state_nxt;
            inta_prev <= inta_n;
            level     <= level_nxt;
            spurious  <= spurious_nxt;
            int_out   <= int_nxt;
            isr       <= isr_nxt;
            clear_irr <= clear_nxt;
            data_out  <= dout_nxt;
            data_oe   <= oe_nxt;
        end
    end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- CPU-facing end of the interrupt path. Takes the one-hot winner from the priority resolver and raises INT to the CPU.
- Runs the two-pulse 8086-mode INTA acknowledge cycle and maintains the In-Service Register (ISR).
- Drives the vector byte onto the data bus on the second INTA pulse and clears ISR bits on EOI or auto-EOI.
- Sits between the priority resolver/IRR and the CPU bus interface.

Parameters:
- SPURIOUS_LEVEL, 7, level reported when no request is present at the first INTA falling edge.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- chosen_interrupt  input  8  one-hot request from the priority resolver; all zeros means no request.
- inta_n  input  1  CPU interrupt acknowledge, active low, synchronous to clk.
- vector_base  input  5  ICW2 bits T7..T3.
- auto_eoi  input  1  1 = clear the ISR bit at the end of the second INTA pulse.
- eoi  input  1  single-cycle EOI command strobe.
- specific_eoi  input  1  qualifies eoi: 1 = clear isr[eoi_level], 0 = clear the highest-priority set ISR bit.
- eoi_level  input  3  target level for a specific EOI.
- int_out  output  1  interrupt request to the CPU.
- isr  output  8  In-Service Register.
- clear_irr  output  8  one-cycle one-hot pulse telling the IRR to drop an edge-latched request.
- data_out  output  8  vector byte.
- data_oe  output  1  data bus drive enable.

Behaviour:
- Reset (async, rst_n=0), all values held until the first clk edge after release:
  - isr=0, int_out=0, clear_irr=0, data_out=0, data_oe=0
  - state=IDLE, inta_prev=1, latched level=0
- Edge detection:
  - inta_n is registered each cycle into inta_prev.
  - fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n.
- Priority rule: fixed, bit 0 highest.
  - req_idx = index of the set bit of chosen_interrupt.
  - A request is eligible when chosen_interrupt != 0 and (isr == 0 or req_idx < index of the lowest set ISR bit).
- IDLE:
  - On an eligible request, go to PENDING and set int_out=1 on the same edge (1-cycle latency from the request).
- PENDING:
  - int_out stays 1 even if chosen_interrupt later drops.
  - On fall: latch level = req_idx, or SPURIOUS_LEVEL if chosen_interrupt == 0.
  - Non-spurious: set isr[level] and pulse clear_irr[level] for exactly 1 cycle.
  - Spurious: no ISR set and no clear_irr pulse.
  - Deassert int_out and go to ACK1.
- ACK1:
  - Wait for rise, then go to GAP.
- GAP:
  - On fall: data_out = {vector_base, level}, data_oe=1, go to ACK2.
  - data_out and data_oe are valid the cycle after inta_n is sampled low.
- ACK2:
  - data_oe stays 1 while inta_n is low.
  - On rise: data_oe=0 and data_out holds its value.
  - If auto_eoi=1 and not spurious, clear isr[level].
  - Go to IDLE. A new request can assert int_out on the following edge.
- EOI (eoi=1, accepted in any state):
  - Non-specific: clear the lowest-index set ISR bit. No effect if isr == 0.
  - Specific: clear isr[eoi_level] unconditionally.
- EOI in the same cycle as an ISR set: clear is evaluated first, then set. If both target the same bit, the set wins and the bit ends at 1.
- EOI during PENDING never deasserts int_out.
- If an EOI makes a pending request eligible, int_out rises on the next edge when in IDLE.
- Mid-cycle reset: state returns to IDLE immediately, data_oe drops asynchronously, isr is cleared.
- A fall while in IDLE (no request) is ignored. A fall in ACK1 before a rise cannot occur because inta_n is already low.
- chosen_interrupt is read only at fall in PENDING; its value in other states does not affect the ISR.

Test Plan:
- Reset, then chosen_interrupt=0x08, vector_base=5'b00001:
  - int_out=1 one cycle later.
  - First INTA: isr=0x08, clear_irr=0x08 for 1 cycle, int_out=0.
  - Second INTA: data_out=0x0B, data_oe=1 while low, 0 after rise.
- isr=0x04 (IR2 in service):
  - chosen_interrupt=0x10: int_out stays 0.
  - chosen_interrupt=0x02: int_out=1, and after the cycle isr=0x06.
- Spurious: chosen_interrupt=0x20 raises int_out, then drops to 0 before INTA.
  - Vector low bits = 7, isr unchanged, clear_irr stays 0.
- auto_eoi=1, IR1, vector_base=0x10:
  - data_out=0x81.
  - isr=0x02 during ACK2, isr=0x00 after the second rise.
- isr=0x05:
  - Non-specific EOI gives 0x04.
  - Specific EOI with eoi_level=2 gives 0x00.
  - Specific EOI with eoi_level=6 on 0x00 stays 0x00.
- rst_n pulled low while data_oe=1 in ACK2:
  - data_oe=0, isr=0, int_out=0 immediately.
  - After release, a fresh INTA with no request does nothing.
